param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 28 ++
 rtl/param_sync_fifo.sv | 115 +++++++++++
 tb/tb_param_sync_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous and asynchronous FIFO family.
package fifo_pkg;

   localparam int FIFO_DEPTH_DEFAULT      = 16;
   localparam int FIFO_DATA_WIDTH_DEFAULT = 8;

   // Smallest n with 2**n >= value; usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH_DEFAULT,
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT,
   parameter int PTR        = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [PTR-1:0]        waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [PTR-1:0]        raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   // Deliberately not reset so the array maps onto plain storage.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with almost flags, sticky error flags and optional FWFT output.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH_DEFAULT,
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT,
   parameter int AF_THRESH  = DEPTH - 4,
   parameter int AE_THRESH  = 2,
   parameter bit FWFT       = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic                      rd_en_i,
   input  logic                      err_clr_i,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic                      almost_full_o,
   output logic                      almost_empty_o,
   output logic [clog2(DEPTH):0]     count_o,
   output logic                      overflow_o,
   output logic                      underflow_o
);

   localparam int PTR = clog2(DEPTH);

   logic [PTR-1:0]        r_wr_ptr;
   logic [PTR-1:0]        r_rd_ptr;
   logic [PTR:0]          r_count;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [DATA_WIDTH-1:0] w_head;
   logic [31:0]           w_count32;

   // Handshake: a write is taken on the rising edge when wr_en_i && !full_o, a read when
   // rd_en_i && !empty_o; any other request is dropped and only raises its sticky error flag.
   assign w_wr_acc = wr_en_i & ~full_o;
   assign w_rd_acc = rd_en_i & ~empty_o;

   assign w_count32      = 32'(r_count);
   assign full_o         = (w_count32 == 32'(DEPTH));
   assign empty_o        = (w_count32 == 32'd0);
   assign almost_full_o  = (w_count32 >= 32'(AF_THRESH));
   assign almost_empty_o = (w_count32 <= 32'(AE_THRESH));
   assign count_o        = r_count;
   assign overflow_o     = r_overflow;
   assign underflow_o    = r_underflow;

   fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .PTR        (PTR)
   ) u_mem (
      .clk     (clk),
      .we_i    (w_wr_acc),
      .waddr_i (r_wr_ptr),
      .wdata_i (wdata_i),
      .raddr_i (r_rd_ptr),
      .rdata_o (w_head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + (PTR+1)'(1);
            2'b01:   r_count <= r_count - (PTR+1)'(1);
            default: r_count <= r_count;
         endcase
         // A new error on the same edge as a clear must survive.
         r_overflow  <= (wr_en_i & full_o)  | (r_overflow  & ~err_clr_i);
         r_underflow <= (rd_en_i & empty_o) | (r_underflow & ~err_clr_i);
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Shadow the head while it is visible so the output can hold once the FIFO drains.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rdata <= '0;
            end else if (!empty_o) begin
               r_rdata <= w_head;
            end
         end
         assign rdata_o = empty_o ? r_rdata : w_head;
      end else begin : g_registered
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rdata <= '0;
            end else if (w_rd_acc) begin
               r_rdata <= w_head;
            end
         end
         assign rdata_o = r_rdata;
      end
   endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised scoreboard bench for param_sync_fifo (registered-read instance) plus FWFT directed checks.
module tb_param_sync_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          full, empty, afull, aempty, ovf, udf;
   logic [CW-1:0] count;

   logic          f_wr_en = 1'b0;
   logic          f_rd_en = 1'b0;
   logic          f_err_clr = 1'b0;
   logic [DW-1:0] f_wdata = '0;
   logic [DW-1:0] f_rdata;
   logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [CW-1:0] f_count;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] m_data[$];
   logic [DW-1:0] m_last = '0;
   bit            m_rd_valid = 1'b0;
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;
   bit            m_wa, m_ra;
   bit            m_was_full, m_was_empty;

   param_sync_fifo #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
      .err_clr_i(err_clr), .rdata_o(rdata), .full_o(full), .empty_o(empty),
      .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
      .overflow_o(ovf), .underflow_o(udf)
   );

   param_sync_fifo #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1'b1)
   ) dut_f (
      .clk(clk), .rst_n(rst_n), .wr_en_i(f_wr_en), .wdata_i(f_wdata), .rd_en_i(f_rd_en),
      .err_clr_i(f_err_clr), .rdata_o(f_rdata), .full_o(f_full), .empty_o(f_empty),
      .almost_full_o(f_afull), .almost_empty_o(f_aempty), .count_o(f_count),
      .overflow_o(f_ovf), .underflow_o(f_udf)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: occupancy is a queue, flags follow from its size
   always @(posedge clk) begin
      if (!rst_n) begin
         m_data.delete();
         exp_q.delete();
         m_rd_valid = 1'b0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_was_full  = (m_data.size() == DEPTH);
         m_was_empty = (m_data.size() == 0);
         m_wa = wr_en && !m_was_full;
         m_ra = rd_en && !m_was_empty;
         m_ovf = (wr_en && m_was_full) || (m_ovf && !err_clr);
         m_udf = (rd_en && m_was_empty) || (m_udf && !err_clr);
         m_rd_valid = m_ra;
         if (m_ra) exp_q.push_back(m_data.pop_front());
         if (m_wa) m_data.push_back(wdata);
      end
   end

   // monitor: pops the scoreboard when a read result is due, checks status every cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         m_last = '0;
      end else begin
         if (m_rd_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rdata_queue actual=empty expected=entry at %0t", $time);
            end else begin
               m_last = exp_q.pop_front();
               check("rdata", 32'(rdata), 32'(m_last));
            end
         end else begin
            check("rdata_hold", 32'(rdata), 32'(m_last));
         end
         check("count", 32'(count), 32'(m_data.size()));
         check("full", 32'(full), 32'(m_data.size() == DEPTH));
         check("empty", 32'(empty), 32'(m_data.size() == 0));
         check("almost_full", 32'(afull), 32'(m_data.size() >= 12));
         check("almost_empty", 32'(aempty), 32'(m_data.size() <= 2));
         check("overflow", 32'(ovf), 32'(m_ovf));
         check("underflow", 32'(udf), 32'(m_udf));
      end
   end

   // driver tasks: called at a falling edge, return at the next falling edge
   task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
      wr_en = w;
      wdata = d;
      rd_en = r;
      err_clr = c;
      @(negedge clk);
   endtask

   task automatic fdrive(input bit w, input logic [DW-1:0] d, input bit r);
      f_wr_en = w;
      f_wdata = d;
      f_rd_en = r;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset_count", 32'(count), 32'd0);
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_aempty", 32'(aempty), 32'd1);
      check("reset_full", 32'(full), 32'd0);
      check("reset_afull", 32'(afull), 32'd0);
      check("reset_rdata", 32'(rdata), 32'd0);
      check("reset_flags", 32'({ovf, udf}), 32'd0);
      rst_n = 1'b1;

      // fill, overflow, drain, underflow, clear
      for (int i = 0; i < 16; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
      check("fill_count", 32'(count), 32'd16);
      check("fill_full", 32'(full), 32'd1);
      check("fill_afull", 32'(afull), 32'd1);
      check("fill_overflow", 32'(ovf), 32'd0);
      for (int i = 16; i < 19; i++) begin
         drive(1'b1, DW'(i), 1'b0, 1'b0);
         check("ovf_set", 32'(ovf), 32'd1);
      end
      check("ovf_count", 32'(count), 32'd16);
      for (int i = 0; i < 18; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         if (i == 15) check("udf_not_yet", 32'(udf), 32'd0);
         if (i == 16) check("udf_set", 32'(udf), 32'd1);
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      check("err_clear", 32'({ovf, udf}), 32'd0);

      // pointer wrap with simultaneous traffic
      for (int i = 0; i < 10; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, DW'($urandom), 1'b1, 1'b0);
         check("simul_count", 32'(count), 32'd4);
      end
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);

      // randomised traffic with phases biased toward full, empty and balanced
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 150; i++) begin
            drive($urandom_range(0, 99) < (ph == 0 ? 80 : (ph == 1 ? 25 : 50)),
                  DW'($urandom),
                  $urandom_range(0, 99) < (ph == 0 ? 30 : (ph == 1 ? 80 : 50)),
                  $urandom_range(0, 19) == 0);
         end
      end

      // reset mid-fill with a pending underflow
      for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
      check("pre_reset_count", 32'(count), 32'd8);
      check("pre_reset_udf", 32'(udf), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_count", 32'(count), 32'd0);
      check("async_rst_empty", 32'(empty), 32'd1);
      check("async_rst_full", 32'(full), 32'd0);
      check("async_rst_flags", 32'({ovf, udf}), 32'd0);
      check("async_rst_rdata", 32'(rdata), 32'd0);
      wr_en = 1'b0;
      rd_en = 1'b0;
      err_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      check("reg_no_read_rdata", 32'(rdata), 32'd0);
      drive(1'b0, '0, 1'b1, 1'b0);
      check("reg_read_rdata", 32'(rdata), 32'hA5);

      // first-word-fall-through instance
      fdrive(1'b1, 8'hA5, 1'b0);
      check("fwft_head", 32'(f_rdata), 32'hA5);
      check("fwft_empty", 32'(f_empty), 32'd0);
      fdrive(1'b1, 8'h3C, 1'b0);
      check("fwft_head_stable", 32'(f_rdata), 32'hA5);
      check("fwft_count", 32'(f_count), 32'd2);
      fdrive(1'b0, '0, 1'b1);
      check("fwft_advance", 32'(f_rdata), 32'h3C);
      fdrive(1'b0, '0, 1'b1);
      check("fwft_drained", 32'(f_empty), 32'd1);
      check("fwft_hold", 32'(f_rdata), 32'h3C);
      fdrive(1'b1, 8'h77, 1'b1);
      check("fwft_simul_udf", 32'(f_udf), 32'd1);
      check("fwft_simul_count", 32'(f_count), 32'd1);
      check("fwft_simul_head", 32'(f_rdata), 32'h77);
      fdrive(1'b0, '0, 1'b0);

      drive(1'b0, '0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
